// File: rtl/rvc_asap_mem_region_router.sv
// rvc_asap data-side router: decodes D-port requests onto memory regions
// and returns read responses in issue order across mixed region latencies.
module rvc_asap_mem_region_router #(
    parameter int NUM_REGIONS = 3,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MAX_LAT     = 2,
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_FLOOR =
        {32'h0040_0000, 32'h0000_3000, 32'h0000_1000},
    parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_ROOF =
        {32'h0040_FFFF, 32'h0000_33FF, 32'h0000_1FFF},
    parameter logic [NUM_REGIONS*3-1:0] REGION_LAT =
        {3'd2, 3'd1, 3'd1}
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          req_valid_i,
    output logic                          req_ready_o,
    input  logic [ADDR_W-1:0]             req_addr_i,
    input  logic [DATA_W-1:0]             req_wr_data_i,
    input  logic [DATA_W/8-1:0]           req_byte_en_i,
    input  logic                          req_wr_en_i,
    output logic [ADDR_W-1:0]             reg_addr_o,
    output logic [DATA_W-1:0]             reg_wr_data_o,
    output logic [DATA_W/8-1:0]           reg_byte_en_o,
    output logic [NUM_REGIONS-1:0]        reg_wr_en_o,
    output logic [NUM_REGIONS-1:0]        reg_rd_en_o,
    input  logic [NUM_REGIONS*DATA_W-1:0] reg_rd_data_i,
    output logic                          rsp_valid_o,
    output logic [DATA_W-1:0]             rsp_data_o,
    output logic                          rsp_fault_o,
    output logic [7:0]                    fault_cnt_o,
    output logic [ADDR_W-1:0]             fault_addr_o
);

    localparam int IW = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;
    localparam int NS = (MAX_LAT > 1) ? MAX_LAT - 1 : 1;

    logic          hit;
    logic [IW-1:0] hit_idx;
    logic [2:0]    hit_lat;
    logic          blocked;
    logic          issue;
    logic          rd_issue;
    logic          wr_issue;

    // Slot j holds a read whose data is sampled j+1 cycles from now.
    logic [NS-1:0] slot_v_q,  slot_v_d;
    logic [NS-1:0] slot_f_q,  slot_f_d;
    logic [IW-1:0] slot_idx_q [NS];
    logic [IW-1:0] slot_idx_d [NS];

    logic              cmp_v;
    logic              cmp_f;
    logic [IW-1:0]     cmp_idx;
    logic [DATA_W-1:0] cmp_data;

    logic              rsp_valid_q;
    logic              rsp_fault_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic [7:0]        fault_cnt_q;
    logic [ADDR_W-1:0] fault_addr_q;

    // Descending scan so the lowest matching index is the one kept.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        hit_lat = 3'd1;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if (req_addr_i >= REGION_FLOOR[i*ADDR_W +: ADDR_W] &&
                req_addr_i <= REGION_ROOF[i*ADDR_W +: ADDR_W]) begin
                hit     = 1'b1;
                hit_idx = IW'(i);
                hit_lat = REGION_LAT[i*3 +: 3];
            end
        end
    end

    always_comb begin
        blocked = 1'b0;
        for (int j = 0; j < MAX_LAT - 1; j++) begin
            if (slot_v_q[j] && (j + 1 >= int'(hit_lat)))
                blocked = 1'b1;
        end
    end

    assign req_ready_o = req_wr_en_i || !blocked;
    assign issue       = req_valid_i && req_ready_o && rst_ni;
    assign rd_issue    = issue && !req_wr_en_i;
    assign wr_issue    = issue && req_wr_en_i;

    always_comb begin
        for (int i = 0; i < NUM_REGIONS; i++) begin
            reg_wr_en_o[i] = wr_issue && hit && (hit_idx == IW'(i));
            reg_rd_en_o[i] = rd_issue && hit && (hit_idx == IW'(i));
        end
    end

    assign reg_addr_o    = req_addr_i;
    assign reg_wr_data_o = req_wr_data_i;
    assign reg_byte_en_o = req_byte_en_i;

    always_comb begin
        slot_v_d = '0;
        slot_f_d = '0;
        for (int k = 0; k < NS; k++)
            slot_idx_d[k] = '0;
        for (int k = 0; k < MAX_LAT - 2; k++) begin
            slot_v_d[k]   = slot_v_q[k+1];
            slot_f_d[k]   = slot_f_q[k+1];
            slot_idx_d[k] = slot_idx_q[k+1];
        end
        for (int k = 0; k < MAX_LAT - 1; k++) begin
            if (rd_issue && (k + 2 == int'(hit_lat))) begin
                slot_v_d[k]   = 1'b1;
                slot_f_d[k]   = !hit;
                slot_idx_d[k] = hit_idx;
            end
        end
    end

    // Latency-1 reads (and unmapped reads) complete in their issue cycle.
    always_comb begin
        if (rd_issue && hit_lat == 3'd1) begin
            cmp_v   = 1'b1;
            cmp_f   = !hit;
            cmp_idx = hit_idx;
        end else begin
            cmp_v   = slot_v_q[0];
            cmp_f   = slot_f_q[0];
            cmp_idx = slot_idx_q[0];
        end
    end

    always_comb begin
        cmp_data = '0;
        for (int i = 0; i < NUM_REGIONS; i++) begin
            if (cmp_idx == IW'(i))
                cmp_data = reg_rd_data_i[i*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            slot_v_q     <= '0;
            slot_f_q     <= '0;
            for (int k = 0; k < NS; k++)
                slot_idx_q[k] <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_fault_q  <= 1'b0;
            rsp_data_q   <= '0;
            fault_cnt_q  <= '0;
            fault_addr_q <= '0;
        end else begin
            slot_v_q <= slot_v_d;
            slot_f_q <= slot_f_d;
            for (int k = 0; k < NS; k++)
                slot_idx_q[k] <= slot_idx_d[k];
            rsp_valid_q <= cmp_v;
            rsp_fault_q <= cmp_v && cmp_f;
            rsp_data_q  <= (cmp_v && !cmp_f) ? cmp_data : '0;
            if (issue && !hit) begin
                if (fault_cnt_q != 8'hFF)
                    fault_cnt_q <= fault_cnt_q + 8'd1;
                if (fault_cnt_q == 8'd0)
                    fault_addr_q <= req_addr_i;
            end
        end
    end

    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_data_o   = rsp_data_q;
    assign rsp_fault_o  = rsp_fault_q;
    assign fault_cnt_o  = fault_cnt_q;
    assign fault_addr_o = fault_addr_q;

endmodule

// File: tb/tb_rvc_asap_mem_region_router.sv
// Bench for rvc_asap_mem_region_router: vector table plus hand sequences,
// read responses tracked by an expected-response queue.
module tb_rvc_asap_mem_region_router;

    localparam logic [31:0] RDV0 = 32'hDEAD_BEEF;
    localparam logic [31:0] RDV1 = 32'hC0DE_0001;
    localparam logic [31:0] RDV2 = 32'h0A0A_5555;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_wr_data;
    logic [3:0]  req_byte_en;
    logic        req_wr_en;
    logic [31:0] reg_addr;
    logic [31:0] reg_wr_data;
    logic [3:0]  reg_byte_en;
    logic [2:0]  reg_wr_en;
    logic [2:0]  reg_rd_en;
    logic [95:0] reg_rd_data;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_fault;
    logic [7:0]  fault_cnt;
    logic [31:0] fault_addr;

    always #5 clk = ~clk;

    assign reg_rd_data = {RDV2, RDV1, RDV0};

    rvc_asap_mem_region_router dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .req_addr_i    (req_addr),
        .req_wr_data_i (req_wr_data),
        .req_byte_en_i (req_byte_en),
        .req_wr_en_i   (req_wr_en),
        .reg_addr_o    (reg_addr),
        .reg_wr_data_o (reg_wr_data),
        .reg_byte_en_o (reg_byte_en),
        .reg_wr_en_o   (reg_wr_en),
        .reg_rd_en_o   (reg_rd_en),
        .reg_rd_data_i (reg_rd_data),
        .rsp_valid_o   (rsp_valid),
        .rsp_data_o    (rsp_data),
        .rsp_fault_o   (rsp_fault),
        .fault_cnt_o   (fault_cnt),
        .fault_addr_o  (fault_addr)
    );

    typedef struct {
        int          cyc;
        logic [31:0] data;
        logic        flt;
    } exp_t;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        rdy;
        logic [2:0]  wren;
        logic [2:0]  rden;
        logic        rsp;
        int          lat;
        logic        flt;
        logic [31:0] data;
    } vec_t;

    exp_t q[$];
    vec_t tbl[12];
    int   cyc    = 0;
    int   errors = 0;
    int   checks = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     n, act, exp, cyc);
        end
    endtask

    task automatic put(input logic v, input logic w, input logic [31:0] a,
                       input logic [3:0] b, input logic [31:0] d);
        req_valid   = v;
        req_wr_en   = w;
        req_addr    = a;
        req_byte_en = b;
        req_wr_data = d;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_rsp(input int lat, input logic [31:0] d,
                              input logic f);
        exp_t e;
        e.cyc  = cyc + lat;
        e.data = d;
        e.flt  = f;
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (q.size() > 0 && q[0].cyc == cyc) begin
            chk("rsp_valid", 64'(rsp_valid), 64'd1);
            chk("rsp_data", 64'(rsp_data), 64'(q[0].data));
            chk("rsp_fault", 64'(rsp_fault), 64'(q[0].flt));
            void'(q.pop_front());
        end else begin
            chk("rsp_idle", 64'(rsp_valid), 64'd0);
        end
    end

    initial begin
        tbl[0]  = '{0, 32'h0000_1004, 4'hF, 32'h0, 1, 3'b000, 3'b001, 1, 1, 0, RDV0};
        tbl[1]  = '{1, 32'h0040_0010, 4'h3, 32'h1234_5678, 1, 3'b100, 3'b000, 0, 0, 0, 32'h0};
        tbl[2]  = '{0, 32'h0040_0000, 4'hF, 32'h0, 1, 3'b000, 3'b100, 1, 2, 0, RDV2};
        tbl[3]  = '{0, 32'h0000_3000, 4'hF, 32'h0, 1, 3'b000, 3'b010, 1, 1, 0, RDV1};
        tbl[4]  = '{0, 32'h0000_33FF, 4'hF, 32'h0, 1, 3'b000, 3'b010, 1, 1, 0, RDV1};
        tbl[5]  = '{0, 32'h0000_3400, 4'hF, 32'h0, 1, 3'b000, 3'b000, 1, 1, 1, 32'h0};
        tbl[6]  = '{0, 32'h0000_0FFF, 4'hF, 32'h0, 1, 3'b000, 3'b000, 1, 1, 1, 32'h0};
        tbl[7]  = '{0, 32'h0000_1FFF, 4'hF, 32'h0, 1, 3'b000, 3'b001, 1, 1, 0, RDV0};
        tbl[8]  = '{0, 32'h0040_FFFF, 4'hF, 32'h0, 1, 3'b000, 3'b100, 1, 2, 0, RDV2};
        tbl[9]  = '{1, 32'h0000_1000, 4'hF, 32'hA5A5_A5A5, 1, 3'b001, 3'b000, 0, 0, 0, 32'h0};
        tbl[10] = '{1, 32'h0000_8004, 4'hF, 32'h0, 1, 3'b000, 3'b000, 0, 0, 0, 32'h0};
        tbl[11] = '{0, 32'h0041_0000, 4'hF, 32'h0, 1, 3'b000, 3'b000, 1, 1, 1, 32'h0};

        rst_n = 1'b0;
        put(1, 0, 32'h0000_1004, 4'hF, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_rden", 64'(reg_rd_en), 64'd0);
        chk("reset_wren", 64'(reg_wr_en), 64'd0);
        chk("reset_rsp_data", 64'(rsp_data), 64'd0);
        chk("reset_rsp_fault", 64'(rsp_fault), 64'd0);
        chk("reset_fault_cnt", 64'(fault_cnt), 64'd0);
        chk("reset_fault_addr", 64'(fault_addr), 64'd0);
        tick();
        rst_n = 1'b1;
        put(0, 0, 32'h0, 4'h0, 32'h0);
        repeat (2) tick();

        // Unmapped read then unmapped write.
        put(1, 0, 32'h0000_8000, 4'hF, 32'h0);
        @(negedge clk);
        chk("unmap_rd_ready", 64'(req_ready), 64'd1);
        chk("unmap_rd_rden", 64'(reg_rd_en), 64'd0);
        expect_rsp(1, 32'h0, 1'b1);
        tick();
        put(1, 1, 32'h0000_9000, 4'hF, 32'h0);
        @(negedge clk);
        chk("fault_cnt_1", 64'(fault_cnt), 64'd1);
        chk("fault_addr_1", 64'(fault_addr), 64'h8000);
        chk("unmap_wr_wren", 64'(reg_wr_en), 64'd0);
        tick();
        put(0, 0, 32'h0, 4'h0, 32'h0);
        @(negedge clk);
        chk("fault_cnt_2", 64'(fault_cnt), 64'd2);
        chk("fault_addr_2", 64'(fault_addr), 64'h8000);
        tick();

        for (int i = 0; i < 12; i++) begin
            put(1, tbl[i].wr, tbl[i].addr, tbl[i].be, tbl[i].wdata);
            @(negedge clk);
            chk($sformatf("vec%0d_ready", i), 64'(req_ready), 64'(tbl[i].rdy));
            chk($sformatf("vec%0d_wren", i), 64'(reg_wr_en), 64'(tbl[i].wren));
            chk($sformatf("vec%0d_rden", i), 64'(reg_rd_en), 64'(tbl[i].rden));
            chk($sformatf("vec%0d_addr", i), 64'(reg_addr), 64'(tbl[i].addr));
            if (tbl[i].wr) begin
                chk($sformatf("vec%0d_be", i), 64'(reg_byte_en), 64'(tbl[i].be));
                chk($sformatf("vec%0d_wdata", i), 64'(reg_wr_data), 64'(tbl[i].wdata));
            end
            if (tbl[i].rsp)
                expect_rsp(tbl[i].lat, tbl[i].data, tbl[i].flt);
            tick();
            put(0, 0, 32'h0, 4'h0, 32'h0);
            repeat (3) tick();
        end
        @(negedge clk);
        chk("fault_cnt_6", 64'(fault_cnt), 64'd6);
        chk("fault_addr_kept", 64'(fault_addr), 64'h8000);
        tick();

        // L=2 read followed by L=1 read stalls one cycle.
        put(1, 0, 32'h0040_0000, 4'hF, 32'h0);
        @(negedge clk);
        chk("ord_l2_ready", 64'(req_ready), 64'd1);
        expect_rsp(2, RDV2, 1'b0);
        tick();
        put(1, 0, 32'h0000_1000, 4'hF, 32'h0);
        @(negedge clk);
        chk("ord_stall_ready", 64'(req_ready), 64'd0);
        chk("ord_stall_rden", 64'(reg_rd_en), 64'd0);
        tick();
        @(negedge clk);
        chk("ord_l1_ready", 64'(req_ready), 64'd1);
        chk("ord_l1_rden", 64'(reg_rd_en), 64'b001);
        expect_rsp(1, RDV0, 1'b0);
        tick();
        put(0, 0, 32'h0, 4'h0, 32'h0);
        repeat (3) tick();

        // A write is not gated while an L=2 read is in flight.
        put(1, 0, 32'h0040_0004, 4'hF, 32'h0);
        @(negedge clk);
        expect_rsp(2, RDV2, 1'b0);
        tick();
        put(1, 1, 32'h0000_1008, 4'hF, 32'h5555_0000);
        @(negedge clk);
        chk("stall_wr_ready", 64'(req_ready), 64'd1);
        chk("stall_wr_wren", 64'(reg_wr_en), 64'b001);
        tick();
        put(0, 0, 32'h0, 4'h0, 32'h0);
        repeat (3) tick();

        for (int k = 0; k < 4; k++) begin
            put(1, 0, 32'h0000_3000 + 32'(4 * k), 4'hF, 32'h0);
            @(negedge clk);
            chk($sformatf("burst%0d_ready", k), 64'(req_ready), 64'd1);
            chk($sformatf("burst%0d_rden", k), 64'(reg_rd_en), 64'b010);
            expect_rsp(1, RDV1, 1'b0);
            tick();
        end
        put(0, 0, 32'h0, 4'h0, 32'h0);
        repeat (3) tick();

        // Reset while an L=2 read is in flight drops it.
        put(1, 0, 32'h0040_0000, 4'hF, 32'h0);
        @(negedge clk);
        chk("flush_ready", 64'(req_ready), 64'd1);
        tick();
        rst_n = 1'b0;
        put(1, 0, 32'h0000_1004, 4'hF, 32'h0);
        @(negedge clk);
        chk("inrst_rden", 64'(reg_rd_en), 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        put(0, 0, 32'h0, 4'h0, 32'h0);
        repeat (3) tick();
        @(negedge clk);
        chk("flush_fault_cnt", 64'(fault_cnt), 64'd0);
        chk("flush_fault_addr", 64'(fault_addr), 64'd0);
        tick();
        put(1, 0, 32'h0000_1004, 4'hF, 32'h0);
        @(negedge clk);
        chk("post_rst_rden", 64'(reg_rd_en), 64'b001);
        expect_rsp(1, RDV0, 1'b0);
        tick();
        put(0, 0, 32'h0, 4'h0, 32'h0);
        repeat (3) tick();

        for (int i = 0; i < 300; i++) begin
            put(1, 1, 32'hF000_0000 + 32'(4 * i), 4'hF, 32'h0);
            tick();
        end
        put(0, 0, 32'h0, 4'h0, 32'h0);
        tick();
        @(negedge clk);
        chk("sat_fault_cnt", 64'(fault_cnt), 64'd255);
        chk("sat_fault_addr", 64'(fault_addr), 64'hF000_0000);
        repeat (2) tick();

        chk("rsp_drained", 64'(q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rvc_asap_mem_region_router.md
Name: rvc_asap_mem_region_router

Overview:
Parametrised data-side memory router for rvc_asap cores. It sits between the core's D-port (one request per cycle) and NUM_REGIONS memory-mapped targets, such as D_MEM, CR_MEM and VGA. It decodes each request against per-region address windows and steers write and read enables to the matching target. Read responses are returned in order, even when regions have different read latencies; the router stalls when in-order return would break. Unmapped accesses are reported as faults.

Parameters:
NUM_REGIONS, 3, number of target regions (1..8).
ADDR_W, 32, request address width.
DATA_W, 32, data width; byte-enable width is DATA_W/8.
MAX_LAT, 2, largest supported region read latency, in cycles (1..4).
REGION_FLOOR, {32'h0040_0000, 32'h0000_3000, 32'h0000_1000}, packed NUM_REGIONS*ADDR_W; inclusive lower bound per region, index 0 in the LSBs.
REGION_ROOF, {32'h0040_FFFF, 32'h0000_33FF, 32'h0000_1FFF}, packed; inclusive upper bound per region.
REGION_LAT, {3'd2, 3'd1, 3'd1}, packed NUM_REGIONS*3; read latency per region, 1..MAX_LAT.

Ports:
Clock  in  1  single clock, rising edge.
Rst  in  1  asynchronous, active-low reset.
ReqValid  in  1  request present.
ReqReady  out  1  request accepted this cycle when ReqValid && ReqReady.
ReqAddr  in  ADDR_W  byte address.
ReqWrData  in  DATA_W  write data.
ReqByteEn  in  DATA_W/8  byte enables.
ReqWrEn  in  1  1 = write, 0 = read.
RegAddr  out  ADDR_W  ReqAddr, broadcast to all regions.
RegWrData  out  DATA_W  ReqWrData, broadcast.
RegByteEn  out  DATA_W/8  ReqByteEn, broadcast.
RegWrEn  out  NUM_REGIONS  one-hot write strobe.
RegRdEn  out  NUM_REGIONS  one-hot read strobe.
RegRdData  in  NUM_REGIONS*DATA_W  per-region read data, valid REGION_LAT[i] cycles after RegRdEn[i].
RspValid  out  1  read response valid.
RspData  out  DATA_W  read data.
RspFault  out  1  response belongs to an unmapped read.
FaultCnt  out  8  saturating count of unmapped accesses.
FaultAddr  out  ADDR_W  address of the first unmapped access since reset.

Behaviour:
- Reset (Rst=0, async): all in-flight slots invalid, RspValid=0, RspData=0, RspFault=0, FaultCnt=0, FaultAddr=0. RegWrEn/RegRdEn are 0 while in reset.
- Any request still in flight when reset asserts is dropped; no response is ever produced for it.
- Decode (combinational): region i matches when REGION_FLOOR[i] <= ReqAddr <= REGION_ROOF[i].
- On overlapping windows, the lowest index wins; the decode result is strictly one-hot.
- No region matches = unmapped.
- Issue happens in cycle t when ReqValid && ReqReady.
- Mapped write: RegWrEn[i]=1 in cycle t only. No response is produced. Writes are always ready.
- Mapped read: RegRdEn[i]=1 in cycle t. RspValid=1 in cycle t+L, where L = REGION_LAT[i].
  - RspData = RegRdData[i] sampled in cycle t+L-1 and registered.
  - For L=1 this is the next cycle after issue, matching sync-read memories.
- Unmapped read: no strobes. It is treated as latency 1. RspValid=1 and RspFault=1 with RspData=0 in cycle t+1.
- Unmapped write: no strobes and no response.
- Any unmapped access (read or write):
  - FaultCnt increments, saturating at 255.
  - FaultAddr captures ReqAddr only when FaultCnt == 0.
- In-flight tracker: MAX_LAT slots, each holding {valid, region index, fault}.
  - Slot k holds the read whose response cycle is k cycles ahead.
  - All slots shift down by one every cycle.
  - A newly issued read of latency L is written into slot L.
- Ordering/stall rule: ReqReady=0 for a read of latency L if any valid slot k >= L exists after this cycle's shift.
  - This prevents both response collision and reordering.
  - ReqReady never depends on ReqValid.
- Back-to-back reads to the same latency never stall, giving full throughput.
- A latency-1 read issued directly after a latency-2 read stalls one cycle.
- Stall-mode writes: a write presented while a read is stalled is not held up by it. A write is always accepted, because only reads are gated.
- At most one RspValid per cycle.
- RspValid is 0 in every cycle with no slot completing.

Test Plan:
1. Reset then read 0x0000_1004: RegRdEn=3'b001 in cycle t; RegRdData[0]=0xDEADBEEF -> RspValid=1, RspData=0xDEADBEEF, RspFault=0 in cycle t+1.
2. Write 0x0040_0010, ByteEn=4'b0011: RegWrEn=3'b100 for exactly one cycle; RspValid stays 0; ReqReady stays 1.
3. Read 0x0040_0000 (L=2) then read 0x0000_1000 (L=1) on consecutive cycles: ReqReady=0 for one cycle; responses appear in cycles t+2 and t+3, VGA data before D_MEM data.
4. Four consecutive reads to 0x0000_3000..0x0000_300C: four RspValid pulses on consecutive cycles with no ReqReady drop.
5. Read 0x0000_8000 (unmapped): RspValid=1, RspFault=1, RspData=0 next cycle; FaultCnt=1, FaultAddr=0x0000_8000. A second unmapped access to 0x0000_9000 -> FaultCnt=2, FaultAddr unchanged. After 300 faults, FaultCnt=255.
6. Issue an L=2 read, then assert Rst one cycle later: RspValid stays 0 through and after reset; FaultCnt=0; the next read behaves as in scenario 1.
